// File: rtl/cordic_pkg.sv
// Shared widths and bundles for the cordic client arbiter.
// Items: operand/result widths, req/rsp structs, index-width helper.
package cordic_pkg;

  localparam int CORDIC_IN_W  = 12;
  localparam int CORDIC_AMP_W = 12;
  localparam int CORDIC_PHI_W = 11;

  typedef struct packed {
    logic signed [CORDIC_IN_W-1:0] re;
    logic signed [CORDIC_IN_W-1:0] im;
  } cordic_req_t;

  typedef struct packed {
    logic        [CORDIC_AMP_W-1:0] amp;
    logic signed [CORDIC_PHI_W-1:0] phi;
  } cordic_rsp_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cordic_tag_fifo.sv
// In-order owner-tag FIFO for cordic transactions in flight.
// Ports: push_i/tag_i, pop_i, full_o, empty_o, count_o, head_o.
module cordic_tag_fifo
  import cordic_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int MAX_OUTST = 4,
  localparam int TW        = idx_w(N_REQ),
  localparam int CW        = $clog2(MAX_OUTST) + 1,
  localparam int PW        = $clog2(MAX_OUTST)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [TW-1:0] tag_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output logic [TW-1:0] head_o
);

  logic [TW-1:0] mem_q [MAX_OUTST];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(MAX_OUTST));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers are exactly log2(depth) wide, so they wrap for free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= tag_i;
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin sharing of one cordic core among N_REQ clients.
// Ports: req_* client operands, rsp_* routed results, core_* core link.
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int MAX_OUTST = 4,
  localparam int TW        = idx_w(N_REQ),
  localparam int CW        = $clog2(MAX_OUTST) + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_REQ*CORDIC_IN_W-1:0] req_re_i,
  input  logic [N_REQ*CORDIC_IN_W-1:0] req_im_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [CORDIC_AMP_W-1:0]   rsp_amp_o,
  output logic [CORDIC_PHI_W-1:0]   rsp_phi_o,
  output logic [N_REQ-1:0]          rsp_valid_o,
  input  logic [N_REQ-1:0]          rsp_ready_i,
  output logic [CORDIC_IN_W-1:0]    core_re_o,
  output logic [CORDIC_IN_W-1:0]    core_im_o,
  output logic                      core_valid_o,
  input  logic                      core_ready_i,
  input  logic [CORDIC_AMP_W-1:0]   core_amp_i,
  input  logic [CORDIC_PHI_W-1:0]   core_phi_i,
  input  logic                      core_valid_i,
  output logic                      core_ready_o,
  output logic [CW-1:0]             inflight_o,
  output logic                      err_o
);

  cordic_req_t   req_a [N_REQ];
  cordic_req_t   sel;
  logic [TW-1:0] ptr_q, ptr_d, gnt, head;
  logic [TW:0]   s;
  logic          err_q, err_d;
  logic          full, empty, issue, pop;

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      req_a[k].re = req_re_i[CORDIC_IN_W*k +: CORDIC_IN_W];
      req_a[k].im = req_im_i[CORDIC_IN_W*k +: CORDIC_IN_W];
    end
  end

  // Walk downward so the closest valid at or above ptr wins.
  always_comb begin
    gnt = ptr_q;
    s   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      s = {1'b0, ptr_q} + (TW+1)'(i);
      if (s >= (TW+1)'(N_REQ)) s = s - (TW+1)'(N_REQ);
      if (req_valid_i[s[TW-1:0]]) gnt = s[TW-1:0];
    end
  end

  assign sel          = req_a[gnt];
  assign core_valid_o = rst_ni & (|req_valid_i) & ~full;
  assign core_re_o    = core_valid_o ? sel.re : '0;
  assign core_im_o    = core_valid_o ? sel.im : '0;
  assign issue        = core_valid_o & core_ready_i;

  always_comb begin
    req_ready_o      = '0;
    req_ready_o[gnt] = rst_ni & core_ready_i & ~full;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (issue) begin
      ptr_d = (gnt == TW'(N_REQ - 1)) ? '0 : gnt + 1'b1;
    end
  end

  always_comb begin
    rsp_valid_o       = '0;
    rsp_valid_o[head] = rst_ni & core_valid_i & ~empty;
  end

  assign core_ready_o = rst_ni & rsp_ready_i[head] & ~empty;
  assign pop          = core_valid_i & core_ready_o;
  assign rsp_amp_o    = core_amp_i;
  assign rsp_phi_o    = core_phi_i;

  // A result with no owner means the core and the tag FIFO disagree.
  assign err_d = err_q | (core_valid_i & empty);
  assign err_o = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end

  cordic_tag_fifo #(
    .N_REQ    (N_REQ),
    .MAX_OUTST(MAX_OUTST)
  ) u_tags (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (issue),
    .tag_i  (gnt),
    .pop_i  (pop),
    .full_o (full),
    .empty_o(empty),
    .count_o(inflight_o),
    .head_o (head)
  );

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with a fixed-latency core model.
// Core model: amp = re + im, phi = re[10:0], latency LAT cycles.
module tb_cordic_arbiter;
  import cordic_pkg::*;

  localparam int N   = 4;
  localparam int M   = 4;
  localparam int LAT = 12;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic [N*12-1:0] req_re_i, req_im_i;
  logic [N-1:0]    req_valid_i, req_ready_o;
  logic [N-1:0]    rsp_valid_o, rsp_ready_i;
  logic [11:0]     rsp_amp_o;
  logic [10:0]     rsp_phi_o;
  logic [11:0]     core_re_o, core_im_o;
  logic            core_valid_o, core_ready_i;
  logic [11:0]     core_amp_i;
  logic [10:0]     core_phi_i;
  logic            core_valid_i, core_ready_o;
  logic [2:0]      inflight_o;
  logic            err_o;

  always #5 clk = ~clk;

  cordic_arbiter #(.N_REQ(N), .MAX_OUTST(M)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_re_i    (req_re_i),
    .req_im_i    (req_im_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .rsp_amp_o   (rsp_amp_o),
    .rsp_phi_o   (rsp_phi_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .core_re_o   (core_re_o),
    .core_im_o   (core_im_o),
    .core_valid_o(core_valid_o),
    .core_ready_i(core_ready_i),
    .core_amp_i  (core_amp_i),
    .core_phi_i  (core_phi_i),
    .core_valid_i(core_valid_i),
    .core_ready_o(core_ready_o),
    .inflight_o  (inflight_o),
    .err_o       (err_o)
  );

  logic        m_en, m_v, inj_v;
  logic [11:0] m_amp;
  logic [10:0] m_phi;
  logic [11:0] base_re [N];
  logic [11:0] base_im [N];
  int          seq [N];
  int          cyc;
  int          n_chk, n_err;

  typedef struct {
    logic [11:0] amp;
    logic [10:0] phi;
    int          due;
  } mq_t;

  typedef struct {
    int          k;
    logic [11:0] amp;
  } rsp_t;

  mq_t  mq [$];
  rsp_t rl [$];
  int   gq [$];

  assign core_valid_i = m_v | inj_v;
  assign core_amp_i   = m_amp;
  assign core_phi_i   = m_phi;

  always_comb begin
    req_re_i = '0;
    req_im_i = '0;
    for (int k = 0; k < N; k++) begin
      req_re_i[12*k +: 12] = base_re[k] + 12'(seq[k]);
      req_im_i[12*k +: 12] = base_im[k];
    end
  end

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      mq.delete();
      cyc   <= 0;
      m_v   <= 1'b0;
      m_amp <= '0;
      m_phi <= '0;
    end else begin
      cyc <= cyc + 1;
      if (core_valid_i && core_ready_o && mq.size() != 0) mq.pop_front();
      if (core_valid_o && core_ready_i)
        mq.push_back('{core_re_o + core_im_o, core_re_o[10:0], cyc + 1 + LAT});
      m_v   <= m_en && mq.size() != 0 && mq[0].due <= cyc + 1;
      m_amp <= (mq.size() != 0) ? mq[0].amp : '0;
      m_phi <= (mq.size() != 0) ? mq[0].phi : '0;
    end
  end

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < N; k++) seq[k] <= 0;
    end else begin
      for (int k = 0; k < N; k++)
        if (req_valid_i[k] && req_ready_o[k]) seq[k] <= seq[k] + 1;
    end
  end

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      gq.delete();
      rl.delete();
    end else begin
      if (core_valid_o && core_ready_i)
        for (int k = 0; k < N; k++)
          if (req_ready_o[k]) gq.push_back(k);
      for (int k = 0; k < N; k++)
        if (rsp_valid_o[k] && rsp_ready_i[k]) rl.push_back('{k, rsp_amp_o});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst();
    rst_ni      = 1'b0;
    req_valid_i = '0;
    inj_v       = 1'b0;
    #1;
    repeat (2) tick();
    rst_ni = 1'b1;
  endtask

  int n, cnt [N];
  bit ok;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    for (int k = 0; k < N; k++) begin
      base_re[k] = '0;
      base_im[k] = '0;
    end
    rst_ni       = 1'b0;
    req_valid_i  = '1;
    core_ready_i = 1'b1;
    rsp_ready_i  = '1;
    inj_v        = 1'b1;
    m_en         = 1'b1;
    #3;
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_core_valid", core_valid_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_core_ready", core_ready_o, 0);
    chk("rst_inflight", inflight_o, 0);
    chk("rst_err", err_o, 0);
    rst();

    // 1: single request, latency and data pass-through
    base_re[0]  = 12'd1000;
    base_im[0]  = 12'd500;
    req_valid_i = 4'b0001;
    tick();
    req_valid_i = '0;
    chk("t1_issue", seq[0], 1);
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (rsp_valid_o != '0) begin
        n = i;
        break;
      end
    end
    chk("t1_latency", n, LAT);
    chk("t1_rsp_valid", rsp_valid_o, 4'b0001);
    chk("t1_amp", rsp_amp_o, 1500);
    chk("t1_phi", rsp_phi_o, 1000);
    tick();
    chk("t1_drained", inflight_o, 0);

    // 2: all requesters valid, round-robin and routing
    rst();
    for (int k = 0; k < N; k++) begin
      base_re[k] = 12'(100 * (k + 1));
      base_im[k] = '0;
    end
    req_valid_i = '1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (gq.size() >= 8) break;
    end
    req_valid_i = '0;
    for (int i = 0; i < 100; i++) begin
      if (inflight_o == 0) break;
      tick();
    end
    chk("t2_issues", gq.size(), 8);
    for (int i = 0; i < gq.size() && i < 8; i++)
      chk("t2_grant", gq[i], i % 4);
    chk("t2_results", rl.size(), 8);
    for (int k = 0; k < N; k++) cnt[k] = 0;
    foreach (rl[i]) begin
      chk("t2_amp", rl[i].amp, 100 * (rl[i].k + 1) + cnt[rl[i].k]);
      cnt[rl[i].k]++;
    end
    for (int k = 0; k < N; k++) chk("t2_count", cnt[k], 2);

    // 3: core never returns, FIFO fills at MAX_OUTST
    rst();
    m_en        = 1'b0;
    base_re[0]  = 12'd50;
    req_valid_i = 4'b0001;
    repeat (6) tick();
    chk("t3_accepted", seq[0], 4);
    chk("t3_ready", req_ready_o, 0);
    chk("t3_core_valid", core_valid_o, 0);
    chk("t3_inflight", inflight_o, 4);

    // 4: pop while full, push only the cycle after
    repeat (12) tick();
    m_en = 1'b1;
    tick();
    m_en = 1'b0;
    chk("t4_rsp_valid", rsp_valid_o, 4'b0001);
    chk("t4_core_ready", core_ready_o, 1);
    chk("t4_no_push", core_valid_o, 0);
    chk("t4_inflight_a", inflight_o, 4);
    tick();
    chk("t4_inflight_b", inflight_o, 3);
    chk("t4_core_valid", core_valid_o, 1);
    tick();
    chk("t4_inflight_c", inflight_o, 4);
    chk("t4_seq", seq[0], 5);
    chk("t4_rl", rl.size(), 1);
    if (rl.size() != 0) chk("t4_amp", rl[0].amp, 50);
    req_valid_i = '0;

    // 5: owner backpressure holds the core result
    rst();
    m_en        = 1'b1;
    rsp_ready_i = 4'b1110;
    base_re[0]  = 12'd300;
    req_valid_i = 4'b0001;
    tick();
    req_valid_i = '0;
    for (int i = 0; i < 30; i++) begin
      if (core_valid_i) break;
      tick();
    end
    chk("t5_core_valid", core_valid_i, 1);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (core_ready_o !== 1'b0 || core_valid_i !== 1'b1 ||
          rsp_valid_o !== 4'b0001 || rsp_amp_o !== 12'd300) ok = 1'b0;
      tick();
    end
    chk("t5_held", ok, 1);
    chk("t5_none_taken", rl.size(), 0);
    rsp_ready_i = '1;
    tick();
    chk("t5_taken", rl.size(), 1);
    if (rl.size() != 0) chk("t5_amp", rl[0].amp, 300);
    chk("t5_inflight", inflight_o, 0);

    // 6: orphan result sets sticky error; reset mid-burst
    rst();
    m_en  = 1'b0;
    inj_v = 1'b1;
    #1;
    chk("t6_rsp_valid", rsp_valid_o, 0);
    chk("t6_core_ready", core_ready_o, 0);
    tick();
    inj_v = 1'b0;
    chk("t6_err", err_o, 1);
    repeat (5) tick();
    chk("t6_err_sticky", err_o, 1);
    m_en = 1'b1;
    for (int k = 0; k < N; k++) base_re[k] = 12'(10 * k);
    req_valid_i = '1;
    repeat (6) tick();
    chk("t6_burst", inflight_o, 4);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6r_core_valid", core_valid_o, 0);
    chk("t6r_req_ready", req_ready_o, 0);
    chk("t6r_rsp_valid", rsp_valid_o, 0);
    chk("t6r_core_ready", core_ready_o, 0);
    chk("t6r_inflight", inflight_o, 0);
    chk("t6r_err", err_o, 0);
    req_valid_i = '0;
    tick();
    rst_ni = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
